// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: parser states and opcodes.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REG_IDX = 3'd1,
    REG_VAL = 3'd2,
    ADDR_HI = 3'd3,
    ADDR_LO = 3'd4,
    DATA    = 3'd5,
    DISCARD = 3'd6
  } state_e;

  localparam logic [7:0] OP_REG_WR = 8'h01;
  localparam logic [7:0] OP_MEM_WR = 8'h02;

endpackage

// File: rtl/spi_cmd_wbuf.sv
// Memory write port: one outstanding request plus a one-byte holding buffer.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   wr_i, addr_i,     byte to write and its address (one-cycle strobe)
//   data_i
//   mem_ack_i         memory accepts when mem_req_o && mem_ack_i
//   mem_req_o, mem_addr_o, mem_data_o   registered request, stable until accepted
//   full_c_o          a wr_i this cycle would be dropped (request stalled, buffer full)
//   req_next_c_o      next-cycle value of mem_req_o
module spi_cmd_wbuf #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        data_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              full_c_o,
  output logic              req_next_c_o
);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              buf_v_q, buf_v_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic              accept;

  assign accept = req_q & mem_ack_i;

  // Output slot refills from the buffer first so byte order is preserved.
  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    data_d     = data_q;
    buf_v_d    = buf_v_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    if (!req_q || accept) begin
      if (buf_v_q) begin
        req_d      = 1'b1;
        addr_d     = buf_addr_q;
        data_d     = buf_data_q;
        buf_v_d    = wr_i;
        buf_addr_d = addr_i;
        buf_data_d = data_i;
      end else if (wr_i) begin
        req_d  = 1'b1;
        addr_d = addr_i;
        data_d = data_i;
      end else begin
        req_d = 1'b0;
      end
    end else if (wr_i && !buf_v_q) begin
      buf_v_d    = 1'b1;
      buf_addr_d = addr_i;
      buf_data_d = data_i;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      buf_v_q    <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      buf_v_q    <= buf_v_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign full_c_o     = req_q & buf_v_q & ~mem_ack_i;
  assign req_next_c_o = req_d;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command parser: register writes (0x01) and memory burst writes (0x02).
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   ByteValid, ByteIn     received SPI byte strobe and value
//   CSel                  chip select (high = frame inactive)
//   MemReq/MemAck, MemAddr, MemData   memory write handshake
//   RegWe, RegAddr, RegData           one-cycle register write strobe
//   Busy                  parser active or memory write outstanding
//   Error                 sticky; cleared by a new frame with a legal opcode
// Build option: define SPI_CMD_AUTOINC_EN to advance the memory address after
// every write; otherwise every data byte goes to the same address.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned REG_N  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ByteValid,
  input  logic [7:0]        ByteIn,
  input  logic              CSel,
  output logic              MemReq,
  input  logic              MemAck,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemData,
  output logic              RegWe,
  output logic [3:0]        RegAddr,
  output logic [7:0]        RegData,
  output logic              Busy,
  output logic              Error
);

  localparam logic [4:0] IDX_LIM = 5'(REG_N);

  state_e            state_q, state_d;
  logic              error_q, error_d;
  logic              reg_we_q, reg_we_d;
  logic [3:0]        reg_addr_q, reg_addr_d;
  logic [7:0]        reg_data_q, reg_data_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q;
  logic              byte_ok;
  logic              wr_c;
  logic              full_c;
  logic              req_next_c;

  assign byte_ok = ByteValid & ~CSel;

  // Next-state and field capture; CSel high always returns to IDLE.
  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    reg_we_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    wr_c       = 1'b0;
    if (CSel) begin
      state_d = IDLE;
    end else if (byte_ok) begin
      case (state_q)
        IDLE: begin
          if (ByteIn == OP_REG_WR) begin
            state_d = REG_IDX;
            error_d = 1'b0;
          end else if (ByteIn == OP_MEM_WR) begin
            state_d = ADDR_HI;
            error_d = 1'b0;
          end else begin
            state_d = DISCARD;
            error_d = 1'b1;
          end
        end
        REG_IDX: begin
          if ({1'b0, ByteIn[3:0]} >= IDX_LIM) begin
            state_d = DISCARD;
            error_d = 1'b1;
          end else begin
            idx_d   = ByteIn[3:0];
            state_d = REG_VAL;
          end
        end
        REG_VAL: begin
          reg_we_d   = 1'b1;
          reg_addr_d = idx_q;
          reg_data_d = ByteIn;
          state_d    = DISCARD;
        end
        ADDR_HI: begin
          hi_d    = ByteIn;
          state_d = ADDR_LO;
        end
        ADDR_LO: begin
          addr_d  = ADDR_W'({hi_q, ByteIn});
          state_d = DATA;
        end
        DATA: begin
          wr_c = 1'b1;
          // Address advances only for bytes the write port actually takes.
          if (full_c) begin
            error_d = 1'b1;
          end else begin
`ifdef SPI_CMD_AUTOINC_EN
            addr_d = addr_q + ADDR_W'(1);
`else
            addr_d = addr_q;
`endif
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      error_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      error_q    <= error_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      busy_q     <= (state_d != IDLE) | req_next_c;
    end
  end

  spi_cmd_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
    .Clk          (Clk),
    .Reset        (Reset),
    .wr_i         (wr_c),
    .addr_i       (addr_q),
    .data_i       (ByteIn),
    .mem_ack_i    (MemAck),
    .mem_req_o    (MemReq),
    .mem_addr_o   (MemAddr),
    .mem_data_o   (MemData),
    .full_c_o     (full_c),
    .req_next_c_o (req_next_c)
  );

  assign RegWe   = reg_we_q;
  assign RegAddr = reg_addr_q;
  assign RegData = reg_data_q;
  assign Busy    = busy_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: frames are modelled as byte lists, the
// expected register/memory writes are queued, and a monitor checks them.
module tb_spi_cmd_ctrl;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned REG_N  = 8;
`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              ByteValid = 1'b0;
  logic [7:0]        ByteIn = 8'h00;
  logic              CSel = 1'b1;
  logic              MemReq;
  logic              MemAck = 1'b0;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemData;
  logic              RegWe;
  logic [3:0]        RegAddr;
  logic [7:0]        RegData;
  logic              Busy;
  logic              Error;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  ack_mode = 0;   // 0 always high, 1 held low, 2 random with bounded stall
  logic exp_err = 1'b0;
  logic [7:0] frame_q[$];
  wr_t mem_q[$];
  wr_t reg_q[$];

  spi_cmd_ctrl #(.ADDR_W(ADDR_W), .REG_N(REG_N)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ByteValid (ByteValid),
    .ByteIn    (ByteIn),
    .CSel      (CSel),
    .MemReq    (MemReq),
    .MemAck    (MemAck),
    .MemAddr   (MemAddr),
    .MemData   (MemData),
    .RegWe     (RegWe),
    .RegAddr   (RegAddr),
    .RegData   (RegData),
    .Busy      (Busy),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory acknowledge driver.
  initial begin
    int low_cnt = 0;
    forever begin
      @(posedge Clk);
      #1;
      case (ack_mode)
        0: MemAck = 1'b1;
        1: MemAck = 1'b0;
        default: begin
          if (low_cnt >= 2 || $urandom_range(1) == 1) begin
            MemAck  = 1'b1;
            low_cnt = 0;
          end else begin
            MemAck = 1'b0;
            low_cnt++;
          end
        end
      endcase
    end
  end

  // Monitor: pops expected writes and checks request stability while stalled.
  logic        prev_pend = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  initial begin
    wr_t e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          chk("req_hold", MemReq, 1);
          chk("addr_hold", MemAddr, prev_addr);
          chk("data_hold", MemData, prev_data);
        end
        if (MemReq && MemAck) begin
          if (mem_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mem_write: got %h/%h, expected none", MemAddr, MemData);
          end else begin
            e = mem_q.pop_front();
            chk("mem_addr", MemAddr, e.addr);
            chk("mem_data", MemData, e.data);
          end
        end
        if (RegWe) begin
          if (reg_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_reg_write: got %h/%h, expected none", RegAddr, RegData);
          end else begin
            e = reg_q.pop_front();
            chk("reg_addr", RegAddr, e.addr);
            chk("reg_data", RegData, e.data);
          end
        end
        prev_pend = MemReq && !MemAck;
        prev_addr = MemAddr;
        prev_data = MemData;
      end
    end
  end

  // Reference model: interprets a whole frame from the command rules.
  task automatic model_frame();
    int n;
    logic [7:0] op;
    logic [15:0] a;
    wr_t w;
    n = frame_q.size();
    if (n == 0) return;
    op = frame_q[0];
    if (op == 8'h01) begin
      exp_err = 1'b0;
      if (n >= 2) begin
        if (int'(frame_q[1] & 8'h0F) >= int'(REG_N)) exp_err = 1'b1;
        else if (n >= 3) begin
          w.addr = 16'(frame_q[1] & 8'h0F);
          w.data = frame_q[2];
          reg_q.push_back(w);
        end
      end
    end else if (op == 8'h02) begin
      exp_err = 1'b0;
      if (n >= 3) begin
        a = {frame_q[1], frame_q[2]};
        for (int i = 3; i < n; i++) begin
          w.addr = a;
          w.data = frame_q[i];
          mem_q.push_back(w);
          if (AUTOINC) a = a + 16'd1;
        end
      end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic send_frame(input int gap);
    CSel = 1'b0;
    @(posedge Clk); #1;
    foreach (frame_q[i]) begin
      ByteValid = 1'b1;
      ByteIn    = frame_q[i];
      @(posedge Clk); #1;
      ByteValid = 1'b0;
      repeat (gap) begin @(posedge Clk); #1; end
    end
    CSel = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (Busy && cnt < 300) begin
      @(posedge Clk); #1;
      cnt++;
    end
    chk("idle_timeout_busy", Busy, 0);
  endtask

  task automatic run(input int gap);
    model_frame();
    send_frame(gap);
    wait_idle();
    chk("error_flag", Error, exp_err);
  endtask

  task automatic check_reset_outputs();
    chk("rst_memreq", MemReq, 0);
    chk("rst_regwe", RegWe, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_error", Error, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_memdata", MemData, 0);
    chk("rst_regaddr", RegAddr, 0);
    chk("rst_regdata", RegData, 0);
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs();
    Reset = 1'b0;
    ack_mode = 0;
    @(posedge Clk); #1;

    // Register write, legal boundary index and illegal index.
    frame_q = '{8'h01, 8'h03, 8'h5A};        run(0);
    frame_q = '{8'h01, 8'h07, 8'hC3, 8'h99}; run(1);
    frame_q = '{8'h01, 8'h08, 8'hC3};        run(0);
    // Memory burst, back-to-back bytes.
    frame_q = '{8'h02, 8'h12, 8'h34, 8'hAA, 8'hBB}; run(0);
    // Illegal opcode, then a legal frame clears the error.
    frame_q = '{8'h7F, 8'h00, 8'h11}; run(0);
    frame_q = '{8'h01, 8'h00, 8'h01}; run(0);
    // Address wrap at the top of the space.
    frame_q = '{8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22}; run(0);
    // Truncated fields are dropped silently.
    frame_q = '{8'h02, 8'h40}; run(0);
    frame_q = '{8'h01, 8'h02}; run(0);

    // Bytes while CSel is high are ignored.
    for (int i = 0; i < 4; i++) begin
      ByteValid = 1'b1;
      ByteIn    = (i == 0) ? 8'h02 : 8'($urandom_range(255));
      @(posedge Clk); #1;
    end
    ByteValid = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    chk("csel_high_busy", Busy, 0);

    // Stalled memory: one pending, one buffered, third byte dropped.
    ack_mode = 1;
    @(posedge Clk); #1;
    frame_q = '{8'h02, 8'h12, 8'h34, 8'hAA, 8'hBB};
    model_frame();
    frame_q.push_back(8'hCC);
    exp_err = 1'b1;
    send_frame(0);
    repeat (15) begin @(posedge Clk); #1; end
    chk("stall_req", MemReq, 1);
    chk("stall_addr", MemAddr, 16'h1234);
    chk("stall_data", MemData, 8'hAA);
    chk("stall_error", Error, 1);
    ack_mode = 0;
    wait_idle();
    chk("stall_error_after", Error, exp_err);

    // Reset while a request is pending discards it.
    ack_mode = 1;
    @(posedge Clk); #1;
    frame_q = '{8'h02, 8'h00, 8'h10, 8'h55};
    send_frame(0);
    chk("pre_reset_req", MemReq, 1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_reset_outputs();
    Reset = 1'b0;
    exp_err = 1'b0;
    mem_q.delete();
    reg_q.delete();
    ack_mode = 0;
    repeat (10) begin @(posedge Clk); #1; end
    chk("post_reset_req", MemReq, 0);

    // Randomised frames with bounded memory stalls.
    ack_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int k;
      int len;
      frame_q.delete();
      k = $urandom_range(2);
      if (k == 0) begin
        frame_q.push_back(8'h01);
        len = $urandom_range(3);
      end else if (k == 1) begin
        frame_q.push_back(8'h02);
        len = $urandom_range(7);
      end else begin
        frame_q.push_back(8'($urandom_range(255)));
        len = $urandom_range(2);
      end
      for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom_range(255)));
      if ($urandom_range(1) == 1) begin
        ByteValid = 1'b1;
        ByteIn    = 8'($urandom_range(255));
        @(posedge Clk); #1;
        ByteValid = 1'b0;
      end
      run($urandom_range(8, 4));
    end

    chk("mem_q_empty", mem_q.size(), 0);
    chk("reg_q_empty", reg_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
